// File: rtl/dma_pkg.sv
// Shared constants and state type for the pixel-memory DMA engines.
// Used by both the read-side and the writeback engine.
package dma_pkg;

    localparam int NUM_WORDS = 76800;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } dma_state_t;

    // Word address successor with wrap at the top of the pixel memory
    function automatic logic [ADDR_W-1:0] addr_inc(
        input logic [ADDR_W-1:0] a
    );
        return (a == ADDR_W'(NUM_WORDS - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push and pop may occur together, including when full.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dma_reader.sv
// Read-side DMA: streams a contiguous word block from memory with credit-based flow control.
// Define DMA_READER_STATS_EN to enable the stall_cycles backpressure counter.
module dma_reader
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [31:0]       stall_cycles
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_remain;
    logic [ADDR_W:0]   r_beat;
    logic              r_inflight;
    logic              r_err;

    logic              w_accept;
    logic              w_bad;
    logic [ADDR_W-1:0] w_len_clamp;
    logic              w_credit;
    logic              w_issue;
    logic              w_hs;
    logic              w_last_beat;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CW-1:0]     w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_bad       = (base_addr >= ADDR_W'(NUM_WORDS));
    assign w_len_clamp = (length > ADDR_W'(NUM_WORDS)) ? ADDR_W'(NUM_WORDS) : length;

    // Reads in flight count against capacity so the FIFO can never overflow
    assign w_credit = !w_fifo_full
                   && ((int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH);
    assign w_issue  = (r_state == RUN) && w_credit;

    assign m_valid     = !w_fifo_empty;
    assign m_data      = m_valid ? w_fifo_head : '0;
    assign w_hs        = m_valid && m_ready;
    assign w_last_beat = (r_beat == ({1'b0, r_len} - 1'b1));
    assign m_last      = m_valid && w_last_beat;

    assign mem_addr = w_issue ? r_next_addr : r_last_addr;
    assign busy     = (r_state == RUN) || (r_state == DRAIN);
    assign done     = (r_state == FIN);
    assign err      = (r_state == FIN) && r_err;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_wdata (mem_rdata),
        .i_pop   (w_hs),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (w_bad || (length == '0)) ? FIN : RUN;
                end
            end
            RUN: begin
                if (w_issue && (r_remain == ADDR_W'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs && w_last_beat) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_next_addr <= '0;
            r_last_addr <= '0;
            r_len       <= '0;
            r_remain    <= '0;
            r_beat      <= '0;
            r_inflight  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_next_addr <= base_addr;
                r_len       <= w_len_clamp;
                r_remain    <= w_len_clamp;
                r_beat      <= '0;
                r_err       <= w_bad;
            end else begin
                if (w_issue) begin
                    r_next_addr <= addr_inc(r_next_addr);
                    r_last_addr <= r_next_addr;
                    r_remain    <= r_remain - 1'b1;
                end
                if (w_hs) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

`ifdef DMA_READER_STATS_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if (m_valid && !m_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_reader.sv
// Randomized scoreboard bench for dma_reader.
// Expected beats are queued at request time and checked by an independent monitor.
module tb_dma_reader;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [16:0] base_addr = '0;
    logic [16:0] length = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [16:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic [31:0] stall_cycles;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    first_v = -1;
    int    beats = 0;
    int    tb_stall = 0;
    int    rmode = 0;
    bit    exp_err = 0;
    bit    last_moved = 0;
    logic        pv = 0;
    logic        pr = 0;
    logic [31:0] pd = '0;
    logic        pl = 0;

    always #5 clk = ~clk;

    dma_reader #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .stall_cycles (stall_cycles)
    );

    function automatic logic [31:0] memf(input int a);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", nm, a, e);
        end
    endtask

    // Synchronous-read memory: data one cycle after address
    always @(posedge clk) mem_rdata <= memf(int'(mem_addr));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && first_v < 0) first_v = cyc - t0;
            if (pv && !pr) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(pd));
                chk("hold_last", 64'(m_last), 64'(pl));
            end
            if (m_valid && !m_ready) tb_stall++;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat got %0h expected none", m_data);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.d));
                    chk("beat_last", 64'(m_last), 64'(e.l));
                end
                beats++;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
        end else begin
            pv = 0;
        end
    end

    task automatic start_xfer(input int b, input int len);
        int  n;
        bit  bad;
        bad = (b >= NUM_WORDS);
        n   = bad ? 0 : ((len > NUM_WORDS) ? NUM_WORDS : len);
        for (int i = 0; i < n; i++) begin
            q.push_back('{d: memf((b + i) % NUM_WORDS), l: (i == n - 1)});
        end
        exp_err = bad;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = 17'(b);
        length    = 17'(len);
        t0        = cyc;
        first_v   = -1;
        beats     = 0;
        tb_stall  = 0;
        @(posedge clk);
        #2;
        start     = 1'b0;
        base_addr = 17'($urandom);
        length    = 17'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        logic [16:0] ma;
        bit          moved;
        int          exp_stall;
        dcyc  = -1;
        moved = 0;
        ma    = mem_addr;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (mem_addr != ma) moved = 1;
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
        end
        last_moved = moved;
        if (dcyc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout got no done expected done within %0d", tag, budget);
        end else begin
`ifdef DMA_READER_STATS_EN
            exp_stall = tb_stall;
`else
            exp_stall = 0;
`endif
            chk({tag, "_err"}, 64'(err), 64'(exp_err));
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_leftover"}, 64'(q.size()), 64'd0);
            chk({tag, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
        end
    endtask

    initial begin
        int d;
        int b;
        int len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        rst_n = 1'b1;

        rmode = 0;
        start_xfer(0, 8);
        wait_done("seq8", 100, d);
        chk("seq8_done_cycle", 64'(d), 64'd11);
        chk("seq8_first_valid", 64'(first_v), 64'd3);

        rmode = 1;
        start_xfer(100, 16);
        wait_done("toggle16", 200, d);

        rmode = 0;
        start_xfer(NUM_WORDS - 2, 4);
        wait_done("wrap4", 100, d);
        chk("wrap4_done_cycle", 64'(d), 64'd7);

        start_xfer(5, 0);
        wait_done("len0", 20, d);
        chk("len0_done_cycle", 64'(d), 64'd1);
        chk("len0_no_valid", 64'(first_v), 64'(-1));
        chk("len0_no_read", 64'(last_moved), 64'd0);

        start_xfer(80000, 5);
        wait_done("badbase", 20, d);
        chk("badbase_done_cycle", 64'(d), 64'd1);
        chk("badbase_no_valid", 64'(first_v), 64'(-1));
        chk("badbase_no_read", 64'(last_moved), 64'd0);

        rmode = 3;
        start_xfer(50, 10);
        repeat (20) @(negedge clk);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_word0", 64'(m_data), 64'(memf(50)));
        chk("stall_reads", 64'(mem_addr), 64'd53);
        chk("stall_busy", 64'(busy), 64'd1);
        rmode = 0;
        wait_done("release10", 100, d);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) != 0) begin
                b = NUM_WORDS - 1 - int'($urandom_range(0, 20));
            end else begin
                b = int'($urandom_range(0, NUM_WORDS - 1));
            end
            len   = int'($urandom_range(1, 30));
            rmode = 2;
            start_xfer(b, len);
            wait_done("rand", 600, d);
        end

        rmode = 0;
        start_xfer(0, 10);
        for (int k = 0; k < 100 && beats < 5; k++) @(negedge clk);
        chk("mid_beats", 64'(beats), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_data", 64'(m_data), 64'd0);
        chk("arst_last", 64'(m_last), 64'd0);
        chk("arst_stall", 64'(stall_cycles), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_xfer(0, 2);
        wait_done("post_rst2", 50, d);
        chk("post_rst2_done_cycle", 64'(d), 64'd5);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
